frame_deser: RTL and testbench
==============================

FRAME_DESER -- requirements
Module: frame_deser

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload bits per frame.
REQ-002 The block SHALL have parameter SYNC_PAT, default 4'b1011, giving the 4-bit frame header, first-received bit in the MSB.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port clear, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port ser_in, input, 1 bit: serial bit stream from the upstream shift-register stage.
REQ-006 Port bit_en, input, 1 bit: ser_in is sampled only on cycles where bit_en=1.
REQ-007 Port data_out, output, DATA_W bits: last good payload, registered.
REQ-008 Port data_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-009 Port frame_err, output, 1 bit: one-cycle pulse on a parity failure.
REQ-010 Port locked, output, 1 bit: level, 1 while the most recent frame passed parity.
REQ-011 Port frame_cnt, output, 8 bits: count of good frames, wrapping.

Function
REQ-012 A frame SHALL be 4 header bits (SYNC_PAT), then DATA_W payload bits MSB-first, then 1 even-parity bit (XOR of payload bits).
REQ-013 The FSM SHALL have exactly three states: HUNT, DATA and PARITY.
REQ-014 In HUNT, each sampled bit SHALL shift into a 4-bit header window.
- Go to DATA on the sample whose bit completes window==SYNC_PAT.
- Compare against the shifted-in value, including the current bit.
REQ-015 Header matching SHALL be sliding: a match SHALL be found at any bit offset, including inside preceding noise.
REQ-016 In DATA, payload bits SHALL be collected into a shift register using a bit counter 0..DATA_W-1.
- The sample with counter=DATA_W-1 SHALL move the FSM to PARITY.
REQ-017 In PARITY, the sampled bit SHALL be compared with the XOR of the collected payload, and the FSM SHALL return to HUNT.
REQ-018 On every entry into HUNT, the header window SHALL be cleared to 0, so a new header consists only of fresh bits.
REQ-019 On a good parity result (next cycle):
- data_out <= payload;
- data_valid=1 for exactly one cycle;
- locked<=1;
- frame_cnt<=frame_cnt+1, modulo 256 (255 wraps to 0).
REQ-020 On a bad parity result (next cycle):
- frame_err=1 for exactly one cycle;
- locked<=0;
- data_out and frame_cnt unchanged.
REQ-021 Latency: data_valid or frame_err SHALL assert in the cycle immediately after the clock edge that sampled the parity bit.
REQ-022 When bit_en=0, FSM, counters and shift registers SHALL hold.
- data_valid and frame_err SHALL still deassert after one cycle and never stretch.
REQ-023 data_valid and frame_err SHALL never be 1 in the same cycle.
REQ-024 ser_in with bit_en=0 SHALL have no effect.

Reset
REQ-025 When clear=0 at a rising clk edge, the following SHALL go to 0: state=HUNT, header window, bit counter, payload register, data_out, data_valid, frame_err, locked and frame_cnt.
REQ-026 clear SHALL take priority over bit_en and all in-progress activity; a partial frame at reset SHALL be discarded with no pulse.
REQ-027 Changes on clear between clock edges SHALL have no effect.

Verification
REQ-028 Good frame: bits 1,0,1,1, 1,0,1,0,0,1,0,1, 0 with bit_en=1 each cycle -> data_out=8'hA5, data_valid high one cycle after the parity sample, locked=1, frame_cnt=1.
REQ-029 Parity error: after REQ-028, frame 1011 + 8'h3C + parity 1 -> frame_err pulse, data_valid stays 0, data_out stays 8'hA5, locked=0, frame_cnt=1.
REQ-030 Sliding hunt: noise 1,1,0,1,0 followed by 1,1 (window completes 1011), then 8'h5A with parity 0 -> data_out=8'h5A, data_valid pulse.
REQ-031 bit_en gating: REQ-028 frame with bit_en alternating 1/0 and ser_in randomised on bit_en=0 cycles -> identical result, with data_valid exactly one cycle wide.
REQ-032 Reset mid-frame: clear=0 for one cycle after 6 payload bits -> all outputs 0 the next cycle, no pulse; a following complete 8'hA5 frame decodes normally.
REQ-033 Counter wrap: 256 consecutive good frames -> frame_cnt returns to 0, with locked=1 throughout after the first frame.

Source files
------------

// File: rtl/frame_deser.sv
// Serial frame deserialiser. The block hunts for a 4-bit sync header with a
// sliding match, collects DATA_W payload bits MSB-first, then checks one
// even-parity bit. Good frames update data_out and the frame counter. Bad
// frames raise a one-cycle error pulse.
module frame_deser #(
    parameter int         DATA_W   = 8,
    parameter logic [3:0] SYNC_PAT = 4'b1011
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              ser_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              locked,
    output logic [7:0]        frame_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   pay_q, pay_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                locked_q, locked_d;
    logic [7:0]          fcnt_q, fcnt_d;
    logic [3:0]          win_next;

    // State register and all datapath registers, with synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update together from
        // the values they held before the edge; blocking = would create order-dependent races.
        if (!clear) begin
            state_q  <= HUNT;
            win_q    <= '0;
            cnt_q    <= '0;
            pay_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            pay_q    <= pay_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Next-state logic. With no bit_en, everything holds except the pulses, which self-clear.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a variable unassigned and infer a latch.
        state_d  = state_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        pay_d    = pay_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        fcnt_d   = fcnt_q;
        win_next = {win_q[2:0], ser_in};

        if (bit_en) begin
            unique case (state_q)
                HUNT: begin
                    // Compare the window including the bit arriving now, so the
                    // match is found at any offset.
                    win_d = win_next;
                    if (win_next == SYNC_PAT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    pay_d = {pay_q[DATA_W-2:0], ser_in};
                    if (cnt_q == CNT_LAST) begin
                        state_d = PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    // Return to HUNT with an empty window. The next header
                    // must then be made only of new bits.
                    state_d = HUNT;
                    win_d   = '0;
                    if (ser_in == ^pay_q) begin
                        dout_d   = pay_q;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                        fcnt_d   = fcnt_q + 8'd1;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    win_d   = '0;
                end
            endcase
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign locked     = locked_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_frame_deser.sv
// Directed bench for frame_deser. A table of frames is applied back to back,
// followed by hand-written sequences for the sliding hunt, bit_en gating,
// reset mid-frame and frame counter wrap.
module tb_frame_deser;

    logic       clk = 1'b0;
    logic       clear;
    logic       ser_in;
    logic       bit_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       locked;
    logic [7:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    frame_deser #(.DATA_W(8), .SYNC_PAT(4'b1011)) dut (
        .clk        (clk),
        .clear      (clear),
        .ser_in     (ser_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .locked     (locked),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] payload;
        logic       par;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_data;
        logic       exp_locked;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bit on the falling edge; the next rising edge samples it.
    task automatic drive_bit(input logic b, input logic en);
        @(negedge clk);
        ser_in = b;
        bit_en = en;
    endtask

    // Send a complete frame. When gated is set, an idle cycle with random
    // ser_in is inserted after every real bit. The task returns on the falling
    // edge after the parity sample, when the result pulse should be visible.
    task automatic send_frame(input logic [7:0] payload, input logic par, input logic gated);
        logic [3:0] hdr;
        hdr = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            drive_bit(hdr[i], 1'b1);
            if (gated) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 7; i >= 0; i--) begin
            drive_bit(payload[i], 1'b1);
            if (gated) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        end
        drive_bit(par, 1'b1);
        drive_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic e,
                                 input logic [7:0] d, input logic l, input logic [7:0] c);
        check({tag, " data_valid"}, 32'(data_valid), 32'(v));
        check({tag, " frame_err"},  32'(frame_err),  32'(e));
        check({tag, " data_out"},   32'(data_out),   32'(d));
        check({tag, " locked"},     32'(locked),     32'(l));
        check({tag, " frame_cnt"},  32'(frame_cnt),  32'(c));
    endtask

    // One cycle later both pulses must have dropped.
    task automatic check_pulse_gone(input string tag);
        drive_bit(1'($urandom_range(0, 1)), 1'b0);
        check({tag, " valid dropped"}, 32'(data_valid), 32'd0);
        check({tag, " err dropped"},   32'(frame_err),  32'd0);
    endtask

    initial begin
        logic [7:0] p;
        logic [7:0] last_cnt;
        logic [3:0] hdr;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd1};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 8'd2};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 8'd3};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 8'd3};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 8'd4};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd5};

        // Reset state.
        clear  = 1'b0;
        ser_in = 1'b1;
        bit_en = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        clear  = 1'b1;
        bit_en = 1'b0;

        // Table of back-to-back frames.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].payload, vecs[i].par, 1'b0);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_err,
                          vecs[i].exp_data, vecs[i].exp_locked, vecs[i].exp_cnt);
            check_pulse_gone($sformatf("vec%0d", i));
        end

        // Sliding hunt: the header completes only after the noise prefix.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        p = 8'h5A;
        for (int i = 7; i >= 0; i--) drive_bit(p[i], 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        check_outputs("slide", 1'b1, 1'b0, 8'h5A, 1'b1, 8'd6);
        check_pulse_gone("slide");

        // Reset mid-frame after six payload bits: everything clears and no pulse follows.
        hdr = 4'b1011;
        p   = 8'hA5;
        for (int i = 3; i >= 0; i--) drive_bit(hdr[i], 1'b1);
        for (int i = 7; i >= 2; i--) drive_bit(p[i], 1'b1);
        @(negedge clk);
        clear  = 1'b0;
        bit_en = 1'b1;
        ser_in = 1'b1;
        @(negedge clk);
        clear  = 1'b1;
        bit_en = 1'b0;
        check_outputs("midreset", 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        drive_bit(1'b0, 1'b0);
        check_outputs("midreset quiet", 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        send_frame(8'hA5, 1'b0, 1'b0);
        check_outputs("after reset", 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1);
        check_pulse_gone("after reset");

        // A glitch on clear between edges must be ignored.
        @(negedge clk);
        bit_en = 1'b0;
        #1 clear = 1'b0;
        #2 clear = 1'b1;
        @(negedge clk);
        check_outputs("clear glitch", 1'b0, 1'b0, 8'hA5, 1'b1, 8'd1);

        // bit_en gating with random ser_in on idle cycles.
        send_frame(8'h3C, 1'b1, 1'b1);
        check_outputs("gated bad", 1'b0, 1'b1, 8'hA5, 1'b0, 8'd1);
        check_pulse_gone("gated bad");
        send_frame(8'hA5, 1'b0, 1'b1);
        check_outputs("gated good", 1'b1, 1'b0, 8'hA5, 1'b1, 8'd2);
        check_pulse_gone("gated good");

        // Counter wrap: 256 good frames from a fresh reset.
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        for (int n = 0; n < 256; n++) begin
            p = 8'($urandom_range(0, 255));
            send_frame(p, ^p, 1'b0);
            check($sformatf("wrap%0d data_valid", n), 32'(data_valid), 32'd1);
            check($sformatf("wrap%0d data_out", n),   32'(data_out),   32'(p));
            check($sformatf("wrap%0d locked", n),     32'(locked),     32'd1);
        end
        last_cnt = frame_cnt;
        check("wrap frame_cnt", 32'(last_cnt), 32'd0);
        check("wrap no err", 32'(frame_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Exclusivity of the two pulses, sampled on every falling edge.
    always @(negedge clk) begin
        if (data_valid && frame_err) begin
            failures++;
            checks++;
            $display("FAIL pulse exclusivity: data_valid=%0b frame_err=%0b expected not both 1",
                     data_valid, frame_err);
        end
    end

endmodule
